// File: rtl/gray_conv_stream.sv
// Streaming binary<->Gray converter with a one-register valid/ready output stage,
// a Gray adjacency checker across accepted samples, and saturating statistics.
module gray_conv_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             step_err,
  input  logic             clr,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // Handshake: a sample moves on accept = in_valid & in_ready and leaves on
  // deliver = out_valid & out_ready; in_ready is high whenever the single
  // output register is empty or being drained in the same cycle.

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_mode_q, out_mode_d;
  logic             step_err_q, step_err_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             ref_valid_q, ref_valid_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] bin_to_gray;
  logic [WIDTH-1:0] gray_to_bin;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] gray_side;
  logic [WIDTH-1:0] diff;
  logic             one_bit_step;
  logic             violation;

  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid_q & out_ready;

  always_comb begin
    bin_to_gray = in_data ^ (in_data >> 1);
    gray_to_bin = '0;
    gray_to_bin[WIDTH-1] = in_data[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      gray_to_bin[i] = gray_to_bin[i+1] ^ in_data[i];
    end
  end

  // The adjacency check always runs on the Gray-side word of the sample.
  assign conv      = in_mode ? gray_to_bin : bin_to_gray;
  assign gray_side = in_mode ? in_data : bin_to_gray;
  assign diff      = gray_side ^ ref_q;

  // Exactly one bit set: non-zero and a power of two.
  assign one_bit_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign violation    = ref_valid_q & ~clr & ~one_bit_step;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_mode_d   = out_mode_q;
    step_err_d   = step_err_q;
    ref_d        = ref_q;
    ref_valid_d  = ref_valid_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = conv;
      out_mode_d  = in_mode;
      step_err_d  = violation;
    end else if (deliver) begin
      out_valid_d = 1'b0;
    end

    // A sample taken alongside clr seeds the fresh reference.
    if (accept) begin
      ref_d       = gray_side;
      ref_valid_d = 1'b1;
    end else if (clr) begin
      ref_valid_d = 1'b0;
    end

    if (clr) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
    end else if (accept) begin
      if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (violation && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mode_q   <= 1'b0;
      step_err_q   <= 1'b0;
      ref_q        <= '0;
      ref_valid_q  <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mode_q   <= out_mode_d;
      step_err_q   <= step_err_d;
      ref_q        <= ref_d;
      ref_valid_q  <= ref_valid_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_mode   = out_mode_q;
  assign step_err   = step_err_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_gray_conv_stream.sv
// Bench for gray_conv_stream: scoreboarded conversions, step checking,
// backpressure, clr, reset and a narrow-counter saturation instance.
module tb_gray_conv_stream;

  localparam int W = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_mode;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready, out_mode, step_err, clr;
  logic [W-1:0] out_data;
  logic [C-1:0] sample_cnt, err_cnt;

  logic         s_in_valid, s_in_ready, s_in_mode;
  logic [W-1:0] s_in_data;
  logic         s_out_valid, s_out_ready, s_out_mode, s_step_err, s_clr;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_sample_cnt, s_err_cnt;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Expected entries are {mode, step_err, data}.
  logic [W+1:0] exp_q[$];
  logic [W-1:0] m_ref;
  logic         m_ref_v;
  int           m_samples;
  int           m_errs;

  always #5 clk = ~clk;

  gray_conv_stream #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .step_err(step_err), .clr(clr), .sample_cnt(sample_cnt), .err_cnt(err_cnt)
  );

  gray_conv_stream #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_mode(s_in_mode), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_mode(s_out_mode),
    .step_err(s_step_err), .clr(s_clr), .sample_cnt(s_sample_cnt), .err_cnt(s_err_cnt)
  );

  function automatic logic [W-1:0] model_conv(input logic [W-1:0] d, input logic m);
    logic [W-1:0] b;
    if (!m) return d ^ (d >> 1);
    b = '0;
    for (int i = W - 1; i >= 0; i--) b[i] = (i == W - 1) ? d[i] : (b[i+1] ^ d[i]);
    return b;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ref_v   = 1'b0;
    m_ref     = '0;
    m_samples = 0;
    m_errs    = 0;
  endfunction

  // Called for every sample at the point the bench knows it will be accepted.
  function automatic void model_accept(input logic [W-1:0] d, input logic m, input logic c);
    logic [W-1:0] g;
    logic         e;
    g = m ? d : model_conv(d, 1'b0);
    e = !c && m_ref_v && ($countones(g ^ m_ref) != 1);
    exp_q.push_back({m, e, model_conv(d, m)});
    m_ref   = g;
    m_ref_v = 1'b1;
    if (c) begin
      m_samples = 0;
      m_errs    = 0;
    end else begin
      if (m_samples < (1 << C) - 1) m_samples++;
      if (e && m_errs < (1 << C) - 1) m_errs++;
    end
  endfunction

  // Scoreboard: every delivery is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      assert_cnt++;
      if (exp_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL scoreboard_unexpected: got data=%b mode=%b err=%b, expected no output",
                 out_data, out_mode, step_err);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        if ({out_mode, step_err, out_data} !== e) begin
          fail_cnt++;
          $display("FAIL scoreboard_data: got mode=%b err=%b data=%b, expected mode=%b err=%b data=%b",
                   out_mode, step_err, out_data, e[W+1], e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample, waits (bounded) for in_ready, returns 1 step after accept.
  task automatic send(input logic [W-1:0] d, input logic m, input logic c);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    clr      = c;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      assert_cnt++;
      fail_cnt++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
    end
    model_accept(d, m, c);
    tick();
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_ref_v   = 1'b0;
    m_samples = 0;
    m_errs    = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    model_reset();
    assert_cnt++;
    if ({out_valid, out_data, out_mode, step_err} !== '0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got valid=%b data=%b mode=%b err=%b, expected all 0",
               out_valid, out_data, out_mode, step_err);
    end
    assert_cnt++;
    if (sample_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL reset_counters: got %0d/%0d, expected 0/0", sample_cnt, err_cnt);
    end
    rst_n = 1'b1;
    tick();
    assert_cnt++;
    if (in_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_conversions();
    logic [W-1:0] din[5]  = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011};
    logic         mode[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] dout[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(din[i], mode[i], 1'b0);
      assert_cnt++;
      if (out_valid !== 1'b1 || out_data !== dout[i] || out_mode !== mode[i]) begin
        fail_cnt++;
        $display("FAIL conv_%0d: got valid=%b data=%b mode=%b, expected valid=1 data=%b mode=%b",
                 i, out_valid, out_data, out_mode, dout[i], mode[i]);
      end
    end
    tick();
  endtask

  task automatic test_step_check();
    logic [W-1:0] grays[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    clr_pulse();
    for (int i = 0; i < 4; i++) begin
      send(W'(i), 1'b0, 1'b0);
      assert_cnt++;
      if (out_data !== grays[i] || step_err !== 1'b0) begin
        fail_cnt++;
        $display("FAIL step_adjacent_%0d: got data=%b err=%b, expected data=%b err=0",
                 i, out_data, step_err, grays[i]);
      end
    end
    assert_cnt++;
    if (sample_cnt !== 8'd4 || err_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL step_counts: got %0d/%0d, expected 4/0", sample_cnt, err_cnt);
    end
    send(4'b0101, 1'b0, 1'b0);
    assert_cnt++;
    if (out_data !== 4'b0111 || step_err !== 1'b1 || err_cnt !== 8'd1) begin
      fail_cnt++;
      $display("FAIL step_jump: got data=%b err=%b err_cnt=%0d, expected 0111/1/1",
               out_data, step_err, err_cnt);
    end
    send(4'b0101, 1'b0, 1'b0);
    assert_cnt++;
    if (step_err !== 1'b1 || err_cnt !== 8'd2) begin
      fail_cnt++;
      $display("FAIL step_repeat: got err=%b err_cnt=%0d, expected 1/2", step_err, err_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure();
    clr_pulse();
    out_ready = 1'b0;
    send(4'b0011, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'b0100;
    in_mode  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      assert_cnt++;
      if (out_valid !== 1'b1 || out_data !== 4'b0010 || in_ready !== 1'b0) begin
        fail_cnt++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%b in_ready=%b, expected 1/0010/0",
                 i, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    model_accept(4'b0100, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    assert_cnt++;
    if (out_valid !== 1'b1 || out_data !== 4'b0110 || sample_cnt !== 8'd2) begin
      fail_cnt++;
      $display("FAIL bp_second: got valid=%b data=%b cnt=%0d, expected 1/0110/2",
               out_valid, out_data, sample_cnt);
    end
    tick();
    assert_cnt++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL bp_drain: got valid=%b pending=%0d, expected 0/0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_clr_accept();
    send(4'b0000, 1'b0, 1'b0);
    send(4'b0101, 1'b0, 1'b1);
    assert_cnt++;
    if (out_data !== 4'b0111 || step_err !== 1'b0 || sample_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL clr_accept: got data=%b err=%b cnt=%0d/%0d, expected 0111/0/0/0",
               out_data, step_err, sample_cnt, err_cnt);
    end
    send(4'b0100, 1'b0, 1'b0);
    assert_cnt++;
    if (step_err !== 1'b0 || sample_cnt !== 8'd1) begin
      fail_cnt++;
      $display("FAIL clr_next: got err=%b cnt=%0d, expected 0/1", step_err, sample_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d;
    logic         m;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = W'($urandom_range(0, (1 << W) - 1));
      m = 1'($urandom_range(0, 1));
      send(d, m, 1'b0);
      assert_cnt++;
      if (out_valid !== 1'b1) begin
        fail_cnt++;
        $display("FAIL b2b_valid_%0d: got %b, expected 1", i, out_valid);
      end
    end
    assert_cnt++;
    if (sample_cnt !== C'(m_samples) || err_cnt !== C'(m_errs)) begin
      fail_cnt++;
      $display("FAIL b2b_counts: got %0d/%0d, expected %0d/%0d",
               sample_cnt, err_cnt, m_samples, m_errs);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(4'b0011, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    tick();
    assert_cnt++;
    if (out_valid !== 1'b0 || sample_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      fail_cnt++;
      $display("FAIL rst_mid: got valid=%b cnt=%0d/%0d, expected 0/0/0",
               out_valid, sample_cnt, err_cnt);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'b1000, 1'b0, 1'b0);
    assert_cnt++;
    if (out_data !== 4'b1100 || step_err !== 1'b0 || sample_cnt !== 8'd1) begin
      fail_cnt++;
      $display("FAIL rst_first: got data=%b err=%b cnt=%0d, expected 1100/0/1",
               out_data, step_err, sample_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    logic [W-1:0] g[5] = '{4'b0000, 4'b0011, 4'b0000, 4'b0011, 4'b0000};
    s_in_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = g[i];
      tick();
    end
    s_in_valid = 1'b0;
    assert_cnt++;
    if (s_sample_cnt !== 2'd3 || s_err_cnt !== 2'd3) begin
      fail_cnt++;
      $display("FAIL sat_counts: got %0d/%0d, expected 3/3", s_sample_cnt, s_err_cnt);
    end
    assert_cnt++;
    if (s_step_err !== 1'b1 || s_out_data !== 4'b0000) begin
      fail_cnt++;
      $display("FAIL sat_last: got err=%b data=%b, expected 1/0000", s_step_err, s_out_data);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = 1'b0; out_ready = 1'b1; clr = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mode = 1'b0; s_out_ready = 1'b1; s_clr = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_conversions();
    test_step_check();
    test_backpressure();
    test_clr_accept();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
